exu_mdu_mc: RTL and testbench

Multi-cycle, parametrised execution unit for the NPC core. It extends the single-cycle integer EXU datapath with the RV32M/RV64M multiply/divide operations. The block sits between IDU and WBU and uses valid/ready handshakes on both sides. ALU operations complete in one cycle; MUL/DIV run on an iterative engine, and the block back-pressures IDU while that engine is busy.

---
 rtl/exu_mdu_mc.sv | 195 +++++++++++++++++++
 tb/tb_exu_mdu_mc.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exu_mdu_mc.sv
// exu_mdu_mc: multi-cycle execution unit for the NPC core.
// Performs the RV32I/RV64I integer ALU operations in a single cycle and the
// RV32M/RV64M multiply/divide operations on an iterative engine. It sits
// between IDU and WBU with valid/ready handshakes on both sides.
//
// Ports:
//   i_clk        clock, all state updates on the rising edge
//   i_rst_n      synchronous active-low reset
//   i_in_valid   IDU offers an operation
//   o_in_ready   operation is accepted when i_in_valid & o_in_ready
//   i_op         5-bit operation code (0..17 defined, 18..31 give 0)
//   i_src1       operand 1 (rs1)
//   i_src2       operand 2 (rs2 or immediate)
//   i_flush      abandon any in-flight operation
//   o_out_valid  registered result available
//   i_out_ready  WBU consumes when o_out_valid & i_out_ready
//   o_result     registered result
//   o_busy       iterative engine running
module exu_mdu_mc #(
    parameter int unsigned XLEN     = 32,
    parameter bit          MUL_FAST = 1'b0
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_in_valid,
    output logic            o_in_ready,
    input  logic [4:0]      i_op,
    input  logic [XLEN-1:0] i_src1,
    input  logic [XLEN-1:0] i_src2,
    input  logic            i_flush,
    output logic            o_out_valid,
    input  logic            i_out_ready,
    output logic [XLEN-1:0] o_result,
    output logic            o_busy
);
    localparam int unsigned CW = $clog2(XLEN);
    localparam logic [CW-1:0]   LAST_CNT = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] MIN_VAL  = {1'b1, {(XLEN-1){1'b0}}};

    localparam logic [4:0] OP_ADD = 5'd0,  OP_SUB = 5'd1,  OP_SLL = 5'd2;
    localparam logic [4:0] OP_SLT = 5'd3,  OP_SLTU = 5'd4, OP_XOR = 5'd5;
    localparam logic [4:0] OP_SRL = 5'd6,  OP_SRA = 5'd7,  OP_OR = 5'd8;
    localparam logic [4:0] OP_AND = 5'd9,  OP_MUL = 5'd10, OP_MULH = 5'd11;
    localparam logic [4:0] OP_MULHSU = 5'd12, OP_MULHU = 5'd13, OP_DIV = 5'd14;
    localparam logic [4:0] OP_DIVU = 5'd15, OP_REM = 5'd16, OP_REMU = 5'd17;

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    state_t            r_state, w_next;
    logic [CW-1:0]     r_cnt;
    logic [XLEN-1:0]   r_a, r_acc, r_q, r_result;
    logic              r_is_mul, r_is_rem, r_mul_hi, r_neg;

    // Operation decode on the live inputs
    logic              w_is_mul, w_is_div, w_is_rem, w_mul_hi, w_div_signed;
    logic              w_sign1, w_sign2, w_div0, w_ovf, w_single;
    logic [XLEN-1:0]   w_mag1, w_mag2, w_fast_result;
    logic [CW-1:0]     w_shamt;
    logic [2*XLEN-1:0] w_fprod;
    logic              w_in_ready, w_accept, w_last;

    always_comb begin
        w_is_mul     = (i_op >= OP_MUL) && (i_op <= OP_MULHU);
        w_is_div     = (i_op >= OP_DIV) && (i_op <= OP_REMU);
        w_is_rem     = (i_op == OP_REM) || (i_op == OP_REMU);
        w_mul_hi     = w_is_mul && (i_op != OP_MUL);
        w_div_signed = (i_op == OP_DIV) || (i_op == OP_REM);
        // MUL only needs the low half, which is sign-agnostic
        w_sign1 = i_src1[XLEN-1] && (w_div_signed || i_op == OP_MULH || i_op == OP_MULHSU);
        w_sign2 = i_src2[XLEN-1] && (w_div_signed || i_op == OP_MULH);
        w_mag1  = w_sign1 ? ('0 - i_src1) : i_src1;
        w_mag2  = w_sign2 ? ('0 - i_src2) : i_src2;
        w_div0  = w_is_div && (i_src2 == '0);
        w_ovf   = w_div_signed && (i_src1 == MIN_VAL) && (i_src2 == '1);
        w_single = w_div0 || w_ovf || !(w_is_mul || w_is_div) || (w_is_mul && MUL_FAST);
        w_shamt = i_src2[CW-1:0];
        w_fprod = {{XLEN{w_sign1}}, i_src1} * {{XLEN{w_sign2}}, i_src2};
    end

    // Result for every operation that completes in the accept cycle
    always_comb begin
        w_fast_result = '0;
        if (w_is_div) begin
            if (w_div0)
                w_fast_result = w_is_rem ? i_src1 : '1;
            else
                w_fast_result = w_is_rem ? '0 : MIN_VAL;
        end else if (w_is_mul) begin
            w_fast_result = w_mul_hi ? w_fprod[2*XLEN-1:XLEN] : w_fprod[XLEN-1:0];
        end else begin
            case (i_op)
                OP_ADD:  w_fast_result = i_src1 + i_src2;
                OP_SUB:  w_fast_result = i_src1 - i_src2;
                OP_SLL:  w_fast_result = i_src1 << w_shamt;
                OP_SLT:  w_fast_result = {{(XLEN-1){1'b0}}, $signed(i_src1) < $signed(i_src2)};
                OP_SLTU: w_fast_result = {{(XLEN-1){1'b0}}, i_src1 < i_src2};
                OP_XOR:  w_fast_result = i_src1 ^ i_src2;
                OP_SRL:  w_fast_result = i_src1 >> w_shamt;
                OP_SRA:  w_fast_result = $signed(i_src1) >>> w_shamt;
                OP_OR:   w_fast_result = i_src1 | i_src2;
                OP_AND:  w_fast_result = i_src1 & i_src2;
                default: w_fast_result = '0;
            endcase
        end
    end

    // One iteration of the engine. Multiply: {acc,q} holds the partial
    // product with the multiplier shifting out of q. Divide: restoring
    // step with acc as remainder and q as dividend/quotient shift register.
    logic [XLEN:0]     w_sum, w_shift, w_diff;
    logic [XLEN-1:0]   w_addend, w_acc_n, w_q_n, w_dval, w_dfix, w_final;
    logic [2*XLEN-1:0] w_prod, w_prod_fix;

    always_comb begin
        w_addend = r_q[0] ? r_a : '0;
        w_sum    = {1'b0, r_acc} + {1'b0, w_addend};
        w_shift  = {r_acc, r_q[XLEN-1]};
        w_diff   = w_shift - {1'b0, r_a};
        if (r_is_mul) begin
            w_acc_n = w_sum[XLEN:1];
            w_q_n   = {w_sum[0], r_q[XLEN-1:1]};
        end else if (!w_diff[XLEN]) begin
            w_acc_n = w_diff[XLEN-1:0];
            w_q_n   = {r_q[XLEN-2:0], 1'b1};
        end else begin
            w_acc_n = w_shift[XLEN-1:0];
            w_q_n   = {r_q[XLEN-2:0], 1'b0};
        end
        w_prod     = {w_acc_n, w_q_n};
        w_prod_fix = r_neg ? ('0 - w_prod) : w_prod;
        w_dval     = r_is_rem ? w_acc_n : w_q_n;
        w_dfix     = r_neg ? ('0 - w_dval) : w_dval;
        if (r_is_mul)
            w_final = r_mul_hi ? w_prod_fix[2*XLEN-1:XLEN] : w_prod_fix[XLEN-1:0];
        else
            w_final = w_dfix;
    end

    assign w_in_ready  = (r_state == S_IDLE) || (r_state == S_DONE && i_out_ready);
    assign w_accept    = w_in_ready && i_in_valid && !i_flush;
    assign w_last      = (r_state == S_CALC) && (r_cnt == LAST_CNT);
    assign o_in_ready  = w_in_ready;
    assign o_out_valid = (r_state == S_DONE);
    assign o_busy      = (r_state == S_CALC);
    assign o_result    = r_result;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_next = w_single ? S_DONE : S_CALC;
            S_CALC: if (w_last) w_next = S_DONE;
            S_DONE: begin
                if (w_accept)         w_next = w_single ? S_DONE : S_CALC;
                else if (i_out_ready) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
        if (i_flush) w_next = S_IDLE;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_cnt    <= '0;
            r_a      <= '0;
            r_acc    <= '0;
            r_q      <= '0;
            r_result <= '0;
            r_is_mul <= 1'b0;
            r_is_rem <= 1'b0;
            r_mul_hi <= 1'b0;
            r_neg    <= 1'b0;
        end else if (w_accept) begin
            r_cnt    <= '0;
            r_acc    <= '0;
            r_a      <= w_is_mul ? w_mag1 : w_mag2;
            r_q      <= w_is_mul ? w_mag2 : w_mag1;
            r_is_mul <= w_is_mul;
            r_is_rem <= w_is_rem;
            r_mul_hi <= w_mul_hi;
            // remainder takes the dividend sign; quotient/product the xor
            r_neg    <= w_is_rem ? w_sign1 : (w_sign1 ^ w_sign2);
            if (w_single) r_result <= w_fast_result;
        end else if (r_state == S_CALC && !i_flush) begin
            r_acc <= w_acc_n;
            r_q   <= w_q_n;
            r_cnt <= r_cnt + 1'b1;
            if (w_last) r_result <= w_final;
        end
    end
endmodule

// File: tb/tb_exu_mdu_mc.sv
module tb_exu_mdu_mc;
    logic        clk, rst_n, in_valid, in_valid_f, flush, out_ready;
    logic [4:0]  op;
    logic [31:0] src1, src2;
    logic        in_ready, out_valid, busy;
    logic        in_ready_f, out_valid_f, busy_f;
    logic [31:0] result, result_f;

    int n_checks = 0;
    int n_pass   = 0;

    exu_mdu_mc #(.XLEN(32), .MUL_FAST(1'b0)) u_dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(in_valid), .o_in_ready(in_ready),
        .i_op(op), .i_src1(src1), .i_src2(src2), .i_flush(flush),
        .o_out_valid(out_valid), .i_out_ready(out_ready), .o_result(result), .o_busy(busy)
    );

    exu_mdu_mc #(.XLEN(32), .MUL_FAST(1'b1)) u_dut_f (
        .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(in_valid_f), .o_in_ready(in_ready_f),
        .i_op(op), .i_src1(src1), .i_src2(src2), .i_flush(flush),
        .o_out_valid(out_valid_f), .i_out_ready(out_ready), .o_result(result_f), .o_busy(busy_f)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, checks so far %0d/%0d", n_pass, n_checks);
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    // Reference model: plain 64-bit arithmetic on the operation definitions
    function automatic logic [31:0] ref_model(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb, p;
        longint unsigned ua, ub, up;
        logic [31:0]     r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        r  = 32'd0;
        case (o)
            5'd0:  r = a + b;
            5'd1:  r = a - b;
            5'd2:  r = a << b[4:0];
            5'd3:  r = (sa < sb) ? 32'd1 : 32'd0;
            5'd4:  r = (a < b) ? 32'd1 : 32'd0;
            5'd5:  r = a ^ b;
            5'd6:  r = a >> b[4:0];
            5'd7:  r = $signed(a) >>> b[4:0];
            5'd8:  r = a | b;
            5'd9:  r = a & b;
            5'd10: begin up = ua * ub; r = up[31:0];  end
            5'd11: begin p = sa * sb;  r = p[63:32];  end
            5'd12: begin p = sa * longint'(ub); r = p[63:32]; end
            5'd13: begin up = ua * ub; r = up[63:32]; end
            5'd14: begin if (b == 0) r = 32'hFFFFFFFF; else begin p = sa / sb; r = p[31:0]; end end
            5'd15: begin if (b == 0) r = 32'hFFFFFFFF; else begin up = ua / ub; r = up[31:0]; end end
            5'd16: begin if (b == 0) r = a; else begin p = sa % sb; r = p[31:0]; end end
            5'd17: begin if (b == 0) r = a; else begin up = ua % ub; r = up[31:0]; end end
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    function automatic int exp_lat(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b, input bit fast);
        bit sgn;
        sgn = (o == 5'd14) || (o == 5'd16);
        if (o >= 5'd10 && o <= 5'd13) return fast ? 1 : 33;
        if (o >= 5'd14 && o <= 5'd17) begin
            if (b == 32'd0 || (sgn && a == 32'h80000000 && b == 32'hFFFFFFFF)) return 1;
            return 33;
        end
        return 1;
    endfunction

    function automatic logic [31:0] rnd_val();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'h80000000;
            2:       return 32'hFFFFFFFF;
            3:       return 32'($urandom_range(0, 16));
            default: return 32'($urandom);
        endcase
    endfunction

    // Issue one op to an idle DUT, measure cycles to out_valid, then consume it
    task automatic do_op(input bit fast, input logic [4:0] o, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output int lat, output int busy_cycles);
        op = o; src1 = a; src2 = b;
        if (fast) in_valid_f = 1'b1;
        else      in_valid   = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; in_valid_f = 1'b0;
        op = 5'($urandom); src1 = $urandom; src2 = $urandom;
        lat = 1;
        busy_cycles = 0;
        while (!(fast ? out_valid_f : out_valid) && lat < 100) begin
            if (fast ? busy_f : busy) busy_cycles++;
            @(posedge clk); #1;
            lat++;
        end
        res = fast ? result_f : result;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    typedef struct {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t tbl[18];

    initial begin
        logic [31:0] res, ra, rb;
        logic [4:0]  ro;
        int          lat, bc, seen;

        tbl[0]  = '{5'd0,  32'd5,          32'd7,          32'd12,         1};
        tbl[1]  = '{5'd7,  32'h80000000,   32'd4,          32'hF8000000,   1};
        tbl[2]  = '{5'd15, 32'd100,        32'd7,          32'd14,         33};
        tbl[3]  = '{5'd17, 32'd100,        32'd7,          32'd2,          33};
        tbl[4]  = '{5'd14, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   33};
        tbl[5]  = '{5'd16, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFF,   33};
        tbl[6]  = '{5'd14, 32'h1234,       32'd0,          32'hFFFFFFFF,   1};
        tbl[7]  = '{5'd16, 32'h1234,       32'd0,          32'h1234,       1};
        tbl[8]  = '{5'd14, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   1};
        tbl[9]  = '{5'd16, 32'h80000000,   32'hFFFFFFFF,   32'd0,          1};
        tbl[10] = '{5'd11, 32'hFFFFFFFE,   32'd3,          32'hFFFFFFFF,   33};
        tbl[11] = '{5'd13, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'hFFFFFFFE,   33};
        tbl[12] = '{5'd10, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'h00000001,   33};
        tbl[13] = '{5'd12, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'hFFFFFFFF,   33};
        tbl[14] = '{5'd4,  32'd1,          32'hFFFFFFFF,   32'd1,          1};
        tbl[15] = '{5'd3,  32'd1,          32'hFFFFFFFF,   32'd0,          1};
        tbl[16] = '{5'd20, 32'd9,          32'd9,          32'd0,          1};
        tbl[17] = '{5'd2,  32'd1,          32'h23,         32'd8,          1};

        rst_n = 1'b0; in_valid = 1'b0; in_valid_f = 1'b0; flush = 1'b0; out_ready = 1'b0;
        op = 5'd0; src1 = 32'd0; src2 = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_result", result, 0);
        check("rst_busy", busy, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_f_out_valid", out_valid_f, 0);
        check("rst_f_result", result_f, 0);
        rst_n = 1'b1;

        // Directed vectors
        for (int i = 0; i < 18; i++) begin
            do_op(1'b0, tbl[i].op, tbl[i].a, tbl[i].b, res, lat, bc);
            check($sformatf("tbl%0d_result", i), res, tbl[i].exp);
            check($sformatf("tbl%0d_latency", i), lat, tbl[i].lat);
        end
        do_op(1'b0, 5'd15, 32'd100, 32'd7, res, lat, bc);
        check("divu_busy_cycles", bc, 32);

        // Single-cycle multiplier instance
        do_op(1'b1, 5'd13, 32'hFFFFFFFF, 32'hFFFFFFFF, res, lat, bc);
        check("fast_mulhu_result", res, 32'hFFFFFFFE);
        check("fast_mulhu_latency", lat, 1);
        do_op(1'b1, 5'd11, 32'hFFFFFFFE, 32'd3, res, lat, bc);
        check("fast_mulh_result", res, 32'hFFFFFFFF);
        do_op(1'b1, 5'd15, 32'd100, 32'd7, res, lat, bc);
        check("fast_divu_latency", lat, 33);

        // Back-pressure then same-cycle accept on release
        op = 5'd0; src1 = 32'd3; src2 = 32'd4; in_valid = 1'b1;
        @(posedge clk); #1;
        op = 5'd1; src1 = 32'd20; src2 = 32'd3;
        for (int i = 0; i < 5; i++) begin
            check("bp_out_valid", out_valid, 1);
            check("bp_result", result, 7);
            check("bp_in_ready", in_ready, 0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_in_ready", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b0;
        check("bp_next_valid", out_valid, 1);
        check("bp_next_result", result, 17);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;

        // Back-to-back single-cycle ops
        out_ready = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            op = 5'd0; src1 = 32'(i * 10); src2 = 32'(i);
            @(posedge clk); #1;
            check($sformatf("thru%0d_valid", i), out_valid, 1);
            check($sformatf("thru%0d_result", i), result, 32'(i * 11));
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("thru_drain_idle", out_valid, 0);

        // Flush at CALC cycle 10
        op = 5'd15; src1 = 32'd1000; src2 = 32'd7; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) begin @(posedge clk); #1; end
        check("flush_busy_before", busy, 1);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush_out_valid", out_valid, 0);
        check("flush_in_ready", in_ready, 1);
        check("flush_busy", busy, 0);
        seen = 0;
        repeat (40) begin
            if (out_valid) seen = 1;
            @(posedge clk); #1;
        end
        check("flush_never_valid", seen, 0);
        do_op(1'b0, 5'd0, 32'd2, 32'd2, res, lat, bc);
        check("post_flush_add", res, 4);
        check("post_flush_latency", lat, 1);

        // Flush together with in_valid drops the op
        op = 5'd0; src1 = 32'd1; src2 = 32'd1; in_valid = 1'b1; flush = 1'b1;
        check("flushv_in_ready", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0;
        check("flushv_out_valid", out_valid, 0);
        check("flushv_busy", busy, 0);
        @(posedge clk); #1;
        check("flushv_out_valid2", out_valid, 0);

        // Reset at CALC cycle 5
        op = 5'd15; src1 = 32'd1000; src2 = 32'd7; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_result", result, 0);
        check("midrst_busy", busy, 0);
        check("midrst_in_ready", in_ready, 1);
        rst_n = 1'b1;
        do_op(1'b0, 5'd15, 32'd100, 32'd7, res, lat, bc);
        check("post_rst_divu", res, 14);
        check("post_rst_latency", lat, 33);

        // Randomized ops against the reference model
        for (int i = 0; i < 200; i++) begin
            ro = 5'($urandom_range(0, 21));
            ra = rnd_val();
            rb = rnd_val();
            do_op(1'b0, ro, ra, rb, res, lat, bc);
            check($sformatf("rnd%0d_op%0d_%h_%h_result", i, ro, ra, rb), res, ref_model(ro, ra, rb));
            check($sformatf("rnd%0d_op%0d_latency", i, ro), lat, exp_lat(ro, ra, rb, 1'b0));
        end
        for (int i = 0; i < 40; i++) begin
            ro = 5'($urandom_range(10, 17));
            ra = rnd_val();
            rb = rnd_val();
            do_op(1'b1, ro, ra, rb, res, lat, bc);
            check($sformatf("frnd%0d_op%0d_%h_%h_result", i, ro, ra, rb), res, ref_model(ro, ra, rb));
            check($sformatf("frnd%0d_op%0d_latency", i, ro), lat, exp_lat(ro, ra, rb, 1'b1));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
